// File: rtl/cache_pkg.sv
// Shared geometry, FSM state type and address field helpers for the direct-mapped cache.
package cache_pkg;

  localparam int unsigned WORD_BITS   = 16;
  localparam int unsigned TAG_BITS    = 12;
  localparam int unsigned INDEX_BITS  = 2;
  localparam int unsigned OFFSET_BITS = 2;
  localparam int unsigned LINE_BITS   = WORD_BITS << OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  function automatic logic [TAG_BITS-1:0] get_tag(input logic [WORD_BITS-1:0] addr);
    return addr[WORD_BITS-1 -: TAG_BITS];
  endfunction

  function automatic logic [INDEX_BITS-1:0] get_index(input logic [WORD_BITS-1:0] addr);
    return addr[OFFSET_BITS +: INDEX_BITS];
  endfunction

  function automatic logic [OFFSET_BITS-1:0] get_offset(input logic [WORD_BITS-1:0] addr);
    return addr[OFFSET_BITS-1:0];
  endfunction

endpackage

// File: rtl/cache_array.sv
// Tag/valid/dirty/data storage: combinational read by index, synchronous line fill or word write.
module cache_array #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned TAG_W  = 12,
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned OFF_W  = 2
) (
  input  logic                         Clk,
  input  logic                         clear,
  input  logic [IDX_W-1:0]             index,
  output logic                         valid,
  output logic                         dirty,
  output logic [TAG_W-1:0]             tag,
  output logic [(WORD_W<<OFF_W)-1:0]   line,
  input  logic                         fill_we,
  input  logic [TAG_W-1:0]             fill_tag,
  input  logic [(WORD_W<<OFF_W)-1:0]   fill_line,
  input  logic                         word_we,
  input  logic [OFF_W-1:0]             word_offset,
  input  logic [WORD_W-1:0]            word_data,
  input  logic                         clean_we
);

  localparam int unsigned LINES  = 1 << IDX_W;
  localparam int unsigned LINE_W = WORD_W << OFF_W;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag   = tag_q[index];
  assign line  = data_q[index];

  // Status bits are the only state that needs clearing; tag/data are qualified by valid.
  always_ff @(posedge Clk) begin
    if (clear) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_we) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
        tag_q[index]   <= fill_tag;
        data_q[index]  <= fill_line;
      end else if (word_we) begin
        dirty_q[index] <= 1'b1;
        data_q[index][32'(word_offset)*WORD_W +: WORD_W] <= word_data;
      end else if (clean_we) begin
        dirty_q[index] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped write-back/write-allocate cache: FSM, hit/miss counters and memory port registers.
module dm_cache #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned INDEX_BITS  = 2,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic                                   Clk,
  input  logic                                   Reset_N,
  input  logic                                   cpu_read,
  input  logic                                   cpu_write,
  input  logic [WORD_SIZE-1:0]                   cpu_address,
  input  logic [WORD_SIZE-1:0]                   cpu_wdata,
  output logic [WORD_SIZE-1:0]                   cpu_rdata,
  output logic                                   cpu_done,
  output logic                                   mem_read,
  output logic                                   mem_write,
  output logic [WORD_SIZE-1:0]                   mem_address,
  output logic [(WORD_SIZE<<OFFSET_BITS)-1:0]    mem_wdata,
  input  logic [(WORD_SIZE<<OFFSET_BITS)-1:0]    mem_rdata,
  input  logic                                   mem_ack,
  output logic [15:0]                            hit_count,
  output logic [15:0]                            miss_count
);

  import cache_pkg::*;

  localparam int unsigned TAG_W  = WORD_SIZE - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned LINE_W = WORD_SIZE << OFFSET_BITS;
  localparam int unsigned CNT_W  = 16;

  logic [TAG_W-1:0]       cpu_tag;
  logic [INDEX_BITS-1:0]  cpu_index;
  logic [OFFSET_BITS-1:0] cpu_offset;
  logic                   req;

  logic                   arr_valid;
  logic                   arr_dirty;
  logic [TAG_W-1:0]       arr_tag;
  logic [LINE_W-1:0]      arr_line;

  state_t                 state_q;
  logic                   mem_read_q;
  logic                   mem_write_q;
  logic [WORD_SIZE-1:0]   mem_addr_q;
  logic [LINE_W-1:0]      mem_wdata_q;
  logic [CNT_W-1:0]       hit_q;
  logic [CNT_W-1:0]       miss_q;
  logic                   was_miss_q;

  logic                   hit_c;
  logic                   fill_c;
  logic                   clean_c;

  assign cpu_tag    = cpu_address[WORD_SIZE-1 -: TAG_W];
  assign cpu_index  = cpu_address[OFFSET_BITS +: INDEX_BITS];
  assign cpu_offset = cpu_address[OFFSET_BITS-1:0];
  assign req        = cpu_read | cpu_write;

  assign hit_c   = (state_q == IDLE) && req && arr_valid && (arr_tag == cpu_tag);
  assign fill_c  = (state_q == ALLOCATE) && mem_ack;
  assign clean_c = (state_q == WRITEBACK) && mem_ack;

  cache_array #(
    .WORD_W (WORD_SIZE),
    .TAG_W  (TAG_W),
    .IDX_W  (INDEX_BITS),
    .OFF_W  (OFFSET_BITS)
  ) u_array (
    .Clk         (Clk),
    .clear       (!Reset_N),
    .index       (cpu_index),
    .valid       (arr_valid),
    .dirty       (arr_dirty),
    .tag         (arr_tag),
    .line        (arr_line),
    .fill_we     (fill_c),
    .fill_tag    (cpu_tag),
    .fill_line   (mem_rdata),
    .word_we     (hit_c && cpu_write),
    .word_offset (cpu_offset),
    .word_data   (cpu_wdata),
    .clean_we    (clean_c)
  );

  // Every output is held at zero while reset is asserted, so an in-flight request vanishes at once.
  assign cpu_done    = hit_c & Reset_N;
  assign cpu_rdata   = cpu_done ? arr_line[32'(cpu_offset)*WORD_SIZE +: WORD_SIZE] : '0;
  assign mem_read    = mem_read_q & Reset_N;
  assign mem_write   = mem_write_q & Reset_N;
  assign mem_address = mem_addr_q & {WORD_SIZE{Reset_N}};
  assign mem_wdata   = mem_wdata_q & {LINE_W{Reset_N}};
  assign hit_count   = hit_q & {CNT_W{Reset_N}};
  assign miss_count  = miss_q & {CNT_W{Reset_N}};

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      was_miss_q  <= 1'b0;
    end else begin
      if (hit_c) begin
        was_miss_q <= 1'b0;
        if (!was_miss_q) hit_q <= hit_q + CNT_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (req && !hit_c) begin
            miss_q     <= miss_q + CNT_W'(1);
            was_miss_q <= 1'b1;
            if (arr_valid && arr_dirty) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {arr_tag, cpu_index, {OFFSET_BITS{1'b0}}};
              mem_wdata_q <= arr_line;
            end else begin
              state_q    <= ALLOCATE;
              mem_read_q <= 1'b1;
              mem_addr_q <= {cpu_tag, cpu_index, {OFFSET_BITS{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            state_q     <= ALLOCATE;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= {cpu_tag, cpu_index, {OFFSET_BITS{1'b0}}};
          end
        end
        ALLOCATE: begin
          if (mem_ack) begin
            state_q    <= IDLE;
            mem_read_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_cache.sv
// Directed bench for dm_cache with a fixed-latency line memory responder.
module tb_dm_cache;

  localparam int unsigned MEM_LAT = 3;

  logic        Clk;
  logic        Reset_N;
  logic        cpu_read;
  logic        cpu_write;
  logic [15:0] cpu_address;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_done;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int          vectors;
  int          miscompares;

  logic [15:0] mem_img [512];
  int          rd_cnt;
  int          wr_cnt;
  int          both_high;
  logic [15:0] last_rd_addr;
  logic [15:0] last_wr_addr;
  logic [63:0] last_wr_data;

  int          cyc;
  logic [15:0] rdata;

  dm_cache dut (
    .Clk         (Clk),
    .Reset_N     (Reset_N),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_done    (cpu_done),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request after a posedge, wait (bounded) for cpu_done, drop it after the completing edge.
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                        output int n, output logic [15:0] rd_data);
    @(posedge Clk); #1;
    cpu_read = rd; cpu_write = wr; cpu_address = a; cpu_wdata = d;
    n = 0;
    forever begin
      @(negedge Clk);
      if (cpu_done) break;
      n++;
      if (n > 60) break;
    end
    rd_data = cpu_rdata;
    @(posedge Clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  // Memory: word at address a initially holds a-3; ack pulses in the MEM_LAT-th cycle of a request.
  initial begin : mem_model
    int cnt;
    int base;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    rd_cnt = 0; wr_cnt = 0; both_high = 0;
    last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0;
    for (int i = 0; i < 512; i++) mem_img[i] = 16'(i - 3);
    forever begin
      @(negedge Clk);
      mem_ack = 1'b0;
      if (mem_read && mem_write) both_high++;
      if (mem_read || mem_write) begin
        cnt++;
        base = int'(mem_address[8:0]);
        if (cnt == 1) begin
          if (mem_write) begin
            wr_cnt++; last_wr_addr = mem_address; last_wr_data = mem_wdata;
          end else begin
            rd_cnt++; last_rd_addr = mem_address;
          end
        end
        if (cnt == MEM_LAT) begin
          cnt = 0;
          mem_ack = 1'b1;
          if (mem_write) begin
            for (int k = 0; k < 4; k++) mem_img[base + k] = mem_wdata[16*k +: 16];
          end else begin
            mem_rdata = {mem_img[base + 3], mem_img[base + 2], mem_img[base + 1], mem_img[base]};
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    Reset_N = 1'b0;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_wdata = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_done", 64'(cpu_done), 64'd0);
    check("rst_memrd", 64'({mem_read, mem_write}), 64'd0);
    check("rst_cnt", 64'({hit_count, miss_count}), 64'd0);
    @(posedge Clk); #1;
    Reset_N = 1'b1;

    // Clean read miss
    do_req(1'b1, 1'b0, 16'h0005, 16'h0, cyc, rdata);
    check("rdmiss_lat", 64'(cyc), 64'(MEM_LAT + 1));
    check("rdmiss_data", 64'(rdata), 64'h0002);
    check("rdmiss_addr", 64'(last_rd_addr), 64'h0004);
    check("rdmiss_nrd", 64'(rd_cnt), 64'd1);
    check("rdmiss_nwr", 64'(wr_cnt), 64'd0);
    check("rdmiss_miss", 64'(miss_count), 64'd1);
    check("rdmiss_hit", 64'(hit_count), 64'd0);

    // Read hit
    do_req(1'b1, 1'b0, 16'h0006, 16'h0, cyc, rdata);
    check("rdhit_lat", 64'(cyc), 64'd0);
    check("rdhit_data", 64'(rdata), 64'h0003);
    check("rdhit_hit", 64'(hit_count), 64'd1);
    check("rdhit_nrd", 64'(rd_cnt), 64'd1);

    // Write hit, then dirty eviction
    do_req(1'b0, 1'b1, 16'h0006, 16'hBEEF, cyc, rdata);
    check("wrhit_lat", 64'(cyc), 64'd0);
    check("wrhit_hit", 64'(hit_count), 64'd2);
    do_req(1'b1, 1'b0, 16'h0046, 16'h0, cyc, rdata);
    check("dirty_lat", 64'(cyc), 64'(2 * MEM_LAT + 1));
    check("dirty_nwr", 64'(wr_cnt), 64'd1);
    check("dirty_wraddr", 64'(last_wr_addr), 64'h0004);
    check("dirty_wrdata", last_wr_data, 64'h0004_BEEF_0002_0001);
    check("dirty_rdaddr", 64'(last_rd_addr), 64'h0044);
    check("dirty_data", 64'(rdata), 64'h0043);
    check("dirty_miss", 64'(miss_count), 64'd2);
    check("dirty_hit", 64'(hit_count), 64'd2);

    // Write miss into a clean (invalid) line
    do_req(1'b0, 1'b1, 16'h0100, 16'h1234, cyc, rdata);
    check("wrmiss_lat", 64'(cyc), 64'(MEM_LAT + 1));
    check("wrmiss_nwr", 64'(wr_cnt), 64'd1);
    check("wrmiss_nrd", 64'(rd_cnt), 64'd3);
    check("wrmiss_miss", 64'(miss_count), 64'd3);
    do_req(1'b1, 1'b0, 16'h0100, 16'h0, cyc, rdata);
    check("wrmiss_rb_lat", 64'(cyc), 64'd0);
    check("wrmiss_rb_data", 64'(rdata), 64'h1234);
    check("wrmiss_rb_hit", 64'(hit_count), 64'd3);

    // Reset during ALLOCATE
    @(posedge Clk); #1;
    cpu_read = 1'b1; cpu_address = 16'h0108;
    @(negedge Clk);
    @(negedge Clk);
    check("rstmid_memrd_pre", 64'(mem_read), 64'd1);
    @(posedge Clk); #1;
    Reset_N = 1'b0;
    @(negedge Clk);
    check("rstmid_memrd", 64'(mem_read), 64'd0);
    check("rstmid_cnt_forced", 64'({hit_count, miss_count}), 64'd0);
    @(posedge Clk); #1;
    Reset_N = 1'b1;
    cpu_read = 1'b0;
    @(negedge Clk);
    check("rstmid_cnt", 64'({hit_count, miss_count}), 64'd0);
    check("rstmid_idle", 64'({mem_read, mem_write}), 64'd0);
    do_req(1'b1, 1'b0, 16'h0108, 16'h0, cyc, rdata);
    check("rstmid_reread_lat", 64'(cyc), 64'(MEM_LAT + 1));
    check("rstmid_reread_data", 64'(rdata), 64'h0105);
    check("rstmid_reread_miss", 64'(miss_count), 64'd1);

    // Read and write together on a hit behave as a write
    do_req(1'b1, 1'b1, 16'h0108, 16'h5555, cyc, rdata);
    check("rw_lat", 64'(cyc), 64'd0);
    check("rw_hit", 64'(hit_count), 64'd1);
    do_req(1'b1, 1'b0, 16'h0148, 16'h0, cyc, rdata);
    check("rw_evict_lat", 64'(cyc), 64'(2 * MEM_LAT + 1));
    check("rw_evict_nwr", 64'(wr_cnt), 64'd2);
    check("rw_evict_wraddr", 64'(last_wr_addr), 64'h0108);
    check("rw_evict_wrdata", last_wr_data, 64'h0108_0107_0106_5555);
    check("rw_evict_rdaddr", 64'(last_rd_addr), 64'h0148);
    check("rw_evict_data", 64'(rdata), 64'h0145);
    check("rw_evict_miss", 64'(miss_count), 64'd2);

    check("mem_exclusive", 64'(both_high), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
